// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_e      - controller FSM states (ST_RUN, ST_MD_WAIT)
//   MD_CNT_W     - width of the mul/div occupancy down-counter
//   REG_ADDR_W   - width of a register-file address
//   REG_ZERO     - register 0, which is hard-wired to zero and never creates a dependency
package hazard_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  localparam int unsigned MD_CNT_W   = 4;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the pipeline-side hazard inputs and the stall/flush controls.
//   master modport - pipeline datapath: drives register indices and E-stage status,
//                    receives stall/flush controls.
//   slave modport  - hazard controller: the reverse.
//   Signals: rs1D, rs2D, rdE, memreadE, branch_takenE, md_startE (pipeline -> controller)
//            stallF, stallD, stallE, flushD, flushE, flushM, md_busy (controller -> pipeline)
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_ADDR_W-1:0] rs1D;
  logic [REG_ADDR_W-1:0] rs2D;
  logic [REG_ADDR_W-1:0] rdE;
  logic                  memreadE;
  logic                  branch_takenE;
  logic                  md_startE;

  logic stallF;
  logic stallD;
  logic stallE;
  logic flushD;
  logic flushE;
  logic flushM;
  logic md_busy;

  modport master (
    output rs1D, rs2D, rdE, memreadE, branch_takenE, md_startE,
    input  stallF, stallD, stallE, flushD, flushE, flushM, md_busy
  );

  modport slave (
    input  rs1D, rs2D, rdE, memreadE, branch_takenE, md_startE,
    output stallF, stallD, stallE, flushD, flushE, flushM, md_busy
  );

endinterface

// File: rtl/hazard_md_timer.sv
// hazard_md_timer: loadable down-counter tracking how long a mul/div still occupies E.
//   clk_i     - clock
//   rst_i     - synchronous active-high reset, clears the count
//   load_i    - load ld_val_i (takes priority over dec_i)
//   ld_val_i  - value to load
//   dec_i     - decrement by one
//   last_o    - count equals 1: the result-ready cycle
module hazard_md_timer
  import hazard_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [MD_CNT_W-1:0] ld_val_i,
  input  logic                dec_i,
  output logic                last_o
);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = ld_val_i;
    else if (dec_i)
      cnt_d = cnt_q - MD_CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == MD_CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the 5-stage pipeline. Handles the hazards
// forwarding cannot: load-use, taken branches resolved in E, and a fixed-latency
// mul/div unit that holds E for MD_LAT cycles.
//   clk, rst            - clock, synchronous active-high reset
//   hz (slave)          - hazard inputs and stall/flush/md_busy outputs
//   stall_cycles        - cycles with stallF=1       (HAZARD_PERF_EN only)
//   flush_events        - cycles with flushD=1       (HAZARD_PERF_EN only)
// Optional feature macro: HAZARD_PERF_EN enables the two performance counters.
// MD_LAT legal range is 2..15.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
)(
  input  logic        clk,
  input  logic        rst,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  hazard_ctrl_if.slave hz
);

  state_e state_q, state_d;
  logic   md_load, md_dec, md_last;
  logic   lu;

  // Register 0 never carries a real value, so a load targeting it cannot stall anyone.
  assign lu = hz.memreadE && (hz.rdE != REG_ZERO) &&
              ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  hazard_md_timer u_md_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (md_load),
    .ld_val_i (MD_CNT_W'(MD_LAT - 1)),
    .dec_i    (md_dec),
    .last_o   (md_last)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  // A taken branch flushes the mul/div out of the way, so it outranks md_startE.
  always_comb begin
    state_d = state_q;
    md_load = 1'b0;
    md_dec  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!hz.branch_takenE && hz.md_startE) begin
          md_load = 1'b1;
          state_d = ST_MD_WAIT;
        end
      end
      ST_MD_WAIT: begin
        if (md_last)
          state_d = ST_RUN;
        else
          md_dec = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are forced quiet during reset. In the ready cycle of MD_WAIT only the
  // load-use check stays live, since E is about to advance normally.
  always_comb begin
    hz.stallF  = 1'b0;
    hz.stallD  = 1'b0;
    hz.stallE  = 1'b0;
    hz.flushD  = 1'b0;
    hz.flushE  = 1'b0;
    hz.flushM  = 1'b0;
    hz.md_busy = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (hz.branch_takenE) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
          end else if (hz.md_startE) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.stallE = 1'b1;
            hz.flushM = 1'b1;
          end else if (lu) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.flushE = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          hz.md_busy = 1'b1;
          if (!md_last) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.stallE = 1'b1;
            hz.flushM = 1'b1;
          end else if (lu) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.flushE = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (hz.stallF) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (hz.flushD) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl with MD_LAT=4.
// Output vector order: {stallF, stallD, stallE, flushD, flushE, flushM, md_busy}.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if hz();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef HAZARD_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
`endif
    .hz           (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_LU     = 7'b1100100;
  localparam logic [6:0] O_BR     = 7'b0001100;
  localparam logic [6:0] O_MDST   = 7'b1110010;
  localparam logic [6:0] O_MDWAIT = 7'b1110011;
  localparam logic [6:0] O_READY  = 7'b0000001;
  localparam logic [6:0] O_RDYLU  = 7'b1100101;

  // Inputs change just after the rising edge so the DUT sees them stable for the whole cycle.
  task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic mr, input logic br,
                               input logic md);
    @(posedge clk);
    #1;
    rst              = r;
    hz.rs1D          = rs1;
    hz.rs2D          = rs2;
    hz.rdE           = rd;
    hz.memreadE      = mr;
    hz.branch_takenE = br;
    hz.md_startE     = md;
  endtask

  // Outputs are sampled on the falling edge, well clear of the state update.
  task automatic checkOutput(input string tag, input logic [6:0] expv);
    logic [6:0] obs;
    @(negedge clk);
    obs = {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM, hz.md_busy};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic checkPerf(input string tag, input logic [31:0] expStall,
                           input logic [31:0] expFlush);
    @(negedge clk);
    checks++;
    assert (stall_cycles === expStall) else begin
      errors++;
      $error("[TB] FAIL %s stall_cycles: observed %0d expected %0d", tag, stall_cycles, expStall);
    end
    checks++;
    assert (flush_events === expFlush) else begin
      errors++;
      $error("[TB] FAIL %s flush_events: observed %0d expected %0d", tag, flush_events, expFlush);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    hz.rs1D = '0; hz.rs2D = '0; hz.rdE = '0;
    hz.memreadE = 1'b0; hz.branch_takenE = 1'b0; hz.md_startE = 1'b0;

    // Reset must mask every request, including a live load-use.
    applyStimulus(1, 5'd7, 5'd0, 5'd7, 1, 1, 1);
    checkOutput("reset_masks_inputs", O_IDLE);
    applyStimulus(1, 5'd7, 5'd0, 5'd7, 1, 1, 1);
    checkOutput("reset_masks_inputs2", O_IDLE);
`ifdef HAZARD_PERF_EN
    checkPerf("perf_reset", 32'd0, 32'd0);
`endif
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("run_after_reset", O_IDLE);

    // Load-use on rs2, single cycle, then rdE=0 never stalls.
    applyStimulus(0, 5'd1, 5'd5, 5'd5, 1, 0, 0);
    checkOutput("lu_rs2", O_LU);
    applyStimulus(0, 5'd1, 5'd5, 5'd9, 0, 0, 0);
    checkOutput("lu_released", O_IDLE);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    checkOutput("lu_rd_zero", O_IDLE);
    applyStimulus(0, 5'd4, 5'd6, 5'd8, 1, 0, 0);
    checkOutput("load_no_dep", O_IDLE);

    // Branch wins over a simultaneous load-use.
    applyStimulus(0, 5'd7, 5'd2, 5'd7, 1, 1, 0);
    checkOutput("branch_over_lu", O_BR);

    // Mul/div with md_startE held: 3 stall cycles, ready cycle, then re-entry.
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    checkOutput("md_t0", O_MDST);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    checkOutput("md_t1", O_MDWAIT);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    checkOutput("md_t2", O_MDWAIT);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    checkOutput("md_t3_ready", O_READY);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    checkOutput("md_reentry", O_MDST);

    // Second mul/div: branch ignored while busy, load-use honoured in ready cycle.
    applyStimulus(0, 5'd3, 5'd0, 5'd3, 1, 1, 0);
    checkOutput("md2_ignores_branch_lu", O_MDWAIT);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("md2_wait", O_MDWAIT);
    applyStimulus(0, 5'd3, 5'd0, 5'd3, 1, 1, 1);
    checkOutput("md2_ready_lu", O_RDYLU);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("md2_back_to_run", O_IDLE);

    // Reset at cnt=2 aborts MD_WAIT; a branch next cycle proves the FSM is in RUN.
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    checkOutput("md3_t0", O_MDST);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("md3_t1", O_MDWAIT);
    applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("md3_reset_cnt2", O_IDLE);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    checkOutput("md3_run_after_reset", O_BR);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("md3_idle", O_IDLE);

`ifdef HAZARD_PERF_EN
    // Counters: one load-use, two branches, one mul/div -> 4 stall cycles, 2 flushes.
    applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("perf_reset_again", O_IDLE);
    applyStimulus(0, 5'd5, 5'd0, 5'd5, 1, 0, 0);
    checkOutput("perf_lu", O_LU);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    checkOutput("perf_br1", O_BR);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    checkOutput("perf_md_t0", O_MDST);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("perf_md_t1", O_MDWAIT);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("perf_md_t2", O_MDWAIT);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("perf_md_ready", O_READY);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    checkOutput("perf_br2", O_BR);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checkPerf("perf_totals", 32'd4, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
